mem_write_seq: RTL
==================

# mem_write_seq

Memory write-cycle sequencer sitting directly downstream of the memory data-out multiplexer. It latches an address and one or two data bytes, and drives the external memory bus through Z80-style T1/T2/(TW)/T3 write cycles. It exposes a start/busy/done handshake to the control unit. For 16-bit writes it issues two back-to-back byte cycles: low byte at `addr`, high byte at `addr+1`.

## Interface

Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request a write cycle; sampled only while `busy`=0
- `word`  in  1  0 = single byte write, 1 = two-byte write; sampled with `start`
- `addr`  in  16  target address; sampled with `start`
- `data_lo`  in  8  first byte, normally the mux `data_out`; sampled with `start`
- `data_hi`  in  8  second byte, used only when `word`=1; sampled with `start`
- `wait_n`  in  1  external wait request, active-low
- `busy`  out  1  high from the cycle after an accepted `start` until the final T3 completes
- `done`  out  1  one-cycle pulse after the last T3
- `mem_addr`  out  16  bus address
- `mem_dout`  out  8  bus write data
- `mem_dout_oe`  out  1  data bus output enable
- `mreq_n`  out  1  memory request, active-low
- `wr_n`  out  1  write strobe, active-low

## Operation

- All outputs are registered.
- Reset values:
  - `busy`=0, `done`=0, `mem_addr`=16'h0000, `mem_dout`=8'h00, `mem_dout_oe`=0, `mreq_n`=1, `wr_n`=1
  - state = IDLE, byte index = 0
- State machine: IDLE, T1, T2, TW, T3.
  - IDLE: `start`=1 → latch `addr`, `data_lo`, `data_hi`, `word`; next state T1.
  - T1: `mem_addr`=current address, `mem_dout`=current byte, `mem_dout_oe`=1, `mreq_n`=0, `wr_n`=1. Next state T2.
  - T2: `wr_n`=0. Next state is TW if `wait_n`=0 at the end of T2, else T3.
  - TW: outputs held as in T2. Stays in TW while `wait_n`=0; moves to T3 when `wait_n`=1.
  - T3: `wr_n`=0, `mreq_n`=0. At the end of T3:
    - if `word`=1 and this was the first byte: address ← address+1 (mod 2^16, so 16'hFFFF wraps to 16'h0000), byte ← `data_hi`, next state T1.
    - otherwise: next state IDLE, `done`=1 for one cycle.
- In IDLE, `mreq_n`=1, `wr_n`=1, `mem_dout_oe`=0. `mem_addr` and `mem_dout` hold their last values.
- Between the two byte cycles of a word write, the bus returns inactive for zero cycles: T3 is followed directly by T1.
- `start` while `busy`=1 is ignored, with no queuing.
- `start` during the `done` cycle is accepted, since the FSM is in IDLE.
- Reset asserted mid-cycle (any state) forces all outputs to their reset values immediately. The pending write is dropped and `done` is not generated.

## Timing

- Start handshake: `start` is sampled at edge 0 and `busy` rises after edge 0.
- Byte write, no waits:
  - T1, T2, T3 occupy the cycles after edges 0, 1, 2.
  - `done` and IDLE occur after edge 3.
  - 3 bus cycles; `done` arrives 4 cycles after the edge that sampled `start`.
- Word write, no waits: 6 bus cycles; `done` arrives 7 cycles after the edge that sampled `start`.
- Each TW adds exactly one cycle. `wait_n` is sampled on the rising edge that ends T2 or TW.
- `wr_n` is low only in T2, TW and T3, and is always nested inside `mreq_n` low.
- `mem_dout` is stable from T1 through T3 of each byte.

## Configuration

- `MEM_WRITE_SEQ_WAIT_EN`:
  - Defined: TW state is present and `wait_n` is honoured as described.
  - Undefined: `wait_n` is ignored (port retained, unconnected internally), TW is not built, and T2 always proceeds to T3.

## Test plan

- Byte write: `start`, `word`=0, `addr`=16'h1234, `data_lo`=8'hA5 → `mem_addr`=16'h1234, `mem_dout`=8'hA5 for 3 cycles; `wr_n` low for 2 cycles; `done` 4 cycles after start.
- Word write with wrap: `word`=1, `addr`=16'hFFFF, lo=8'h11, hi=8'h22 → 8'h11 written at 16'hFFFF, then 8'h22 at 16'h0000; `done` at cycle 7.
- Wait states (macro defined): `wait_n`=0 for 2 edges during a byte write → 2 TW cycles; `done` at cycle 6. With the macro undefined, the same stimulus gives `done` at cycle 4.
- `start` pulsed while `busy`=1 → ignored, with no extra bus cycle. `start` during the `done` cycle → accepted, and T1 follows immediately.
- `reset` asserted during T2 of the high byte of a word write → `mreq_n`=`wr_n`=1 and `mem_dout_oe`=0 immediately; no `done`; IDLE after release.
- Back-to-back byte writes to 16'h0000 and 16'h0001 → bus strobes match the protocol with no overlap between cycles.

Source files
------------

// File: rtl/mem_write_seq.sv
// mem_write_seq: memory write-cycle sequencer (Z80-style T1/T2/TW/T3).
// Latches an address and one or two data bytes on start, then drives the
// external memory bus through one byte cycle, or two consecutive byte cycles
// for a word write (low byte at addr, high byte at addr+1).
// Optional feature macro: MEM_WRITE_SEQ_WAIT_EN builds the TW state and
// honours wait_n. Without it, wait_n is ignored and T2 always goes to T3.
module mem_write_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        word,
  input  logic [15:0] addr,
  input  logic [7:0]  data_lo,
  input  logic [7:0]  data_hi,
  input  logic        wait_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        mem_dout_oe,
  output logic        mreq_n,
  output logic        wr_n
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
`ifdef MEM_WRITE_SEQ_WAIT_EN
    ST_TW,
`endif
    ST_T3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Transaction context captured at start
  logic        r_word;
  logic [7:0]  r_data_hi;
  logic        r_second;      // 0 while writing the first byte, 1 for the second

  // Registered bus outputs
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_dout;
  logic        r_mem_dout_oe;
  logic        r_mreq_n;
  logic        r_wr_n;

  // Decoded transitions
  logic        w_load_first;  // IDLE accepting a new request
  logic        w_load_second; // T3 of first byte of a word write rolling into T1
  logic        w_last_t3;     // final T3 of the transaction ends this cycle
  logic [15:0] w_addr_next;
  logic [7:0]  w_dout_next;

`ifndef MEM_WRITE_SEQ_WAIT_EN
  logic        w_unused_wait_n;
  assign w_unused_wait_n = wait_n;
`endif

  // Next-state decode and next bus address/data selection
  always_comb begin
    w_state_next  = r_state;
    w_load_first  = 1'b0;
    w_load_second = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_T1;
          w_load_first = 1'b1;
        end
      end
      ST_T1: w_state_next = ST_T2;
      ST_T2: begin
`ifdef MEM_WRITE_SEQ_WAIT_EN
        w_state_next = wait_n ? ST_T3 : ST_TW;
`else
        w_state_next = ST_T3;
`endif
      end
`ifdef MEM_WRITE_SEQ_WAIT_EN
      ST_TW: begin
        if (wait_n) begin
          w_state_next = ST_T3;
        end
      end
`endif
      ST_T3: begin
        if (r_word && !r_second) begin
          w_state_next  = ST_T1;
          w_load_second = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    w_last_t3 = (r_state == ST_T3) && !w_load_second;

    // Address and data only change when a byte cycle begins; 16-bit add wraps
    w_addr_next = r_mem_addr;
    w_dout_next = r_mem_dout;
    if (w_load_first) begin
      w_addr_next = addr;
      w_dout_next = data_lo;
    end else if (w_load_second) begin
      w_addr_next = r_mem_addr + 16'd1;
      w_dout_next = r_data_hi;
    end
  end

  // State register and transaction context
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_word    <= 1'b0;
      r_data_hi <= 8'h00;
      r_second  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load_first) begin
        r_word    <= word;
        r_data_hi <= data_hi;
        r_second  <= 1'b0;
      end else if (w_load_second) begin
        r_second  <= 1'b1;
      end
    end
  end

  // Outputs are registered from the upcoming state so each strobe is glitch-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_mem_addr    <= 16'h0000;
      r_mem_dout    <= 8'h00;
      r_mem_dout_oe <= 1'b0;
      r_mreq_n      <= 1'b1;
      r_wr_n        <= 1'b1;
    end else begin
      r_busy        <= (w_state_next != ST_IDLE);
      r_done        <= w_last_t3;
      r_mem_addr    <= w_addr_next;
      r_mem_dout    <= w_dout_next;
      r_mem_dout_oe <= (w_state_next != ST_IDLE);
      r_mreq_n      <= (w_state_next == ST_IDLE);
      r_wr_n        <= (w_state_next == ST_IDLE) || (w_state_next == ST_T1);
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign mem_addr    = r_mem_addr;
  assign mem_dout    = r_mem_dout;
  assign mem_dout_oe = r_mem_dout_oe;
  assign mreq_n      = r_mreq_n;
  assign wr_n        = r_wr_n;

endmodule
